// File: rtl/prescaler_prog.sv
// ---------------------------------------------------------------------------
// prescaler_prog
//
// Programmable-period clock prescaler. It divides clk_in by a runtime
// divisor P (2..2^N-1). It produces a registered divided clock (clk_out,
// square wave or single-cycle pulse) and a registered one-cycle tick at
// every period wrap. New divisors are captured by div_load and applied only
// at a period boundary (a wrap or a restart), so clk_out never glitches.
//
// Optional feature macro: PRESCALER_ONESHOT_EN
//   Adds 'oneshot' and 'running'. With oneshot high, the wrap that raises
//   tick also stops the counter until the next restart.
//
// Parameters:
//   N           counter and divisor width
//   DIV_DEFAULT divisor after reset (values below 2 become 2)
//
// Ports:
//   clk_in    in   system clock
//   rst       in   synchronous reset, active high
//   ena       in   count enable; low freezes the counter
//   restart   in   synchronous phase restart (takes priority over ena)
//   mode      in   0 = square-wave clk_out, 1 = pulse clk_out
//   div_in    in   new divisor value
//   div_load  in   one-cycle strobe that captures div_in
//   div_pend  out  a captured divisor is waiting for the next boundary
//   clk_out   out  divided clock, registered
//   tick      out  one-cycle strobe per period, registered
//   oneshot   in   (PRESCALER_ONESHOT_EN) stop after the next wrap
//   running   out  (PRESCALER_ONESHOT_EN) counter is not stopped
// ---------------------------------------------------------------------------
module prescaler_prog #(
   parameter int N           = 24,
   parameter int DIV_DEFAULT = 12000000
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         ena,
   input  logic         restart,
   input  logic         mode,
   input  logic [N-1:0] div_in,
   input  logic         div_load,
   output logic         div_pend,
   output logic         clk_out,
`ifdef PRESCALER_ONESHOT_EN
   output logic         tick,
   input  logic         oneshot,
   output logic         running
`else
   output logic         tick
`endif
);

   // Divisors of 0 or 1 cannot form a period, so they are stored as 2.
   localparam logic [N-1:0] DIV_RST = (DIV_DEFAULT < 2) ? N'(2) : N'(DIV_DEFAULT);

   function automatic logic [N-1:0] clamp_div(input logic [N-1:0] v);
      return (v < N'(2)) ? N'(2) : v;
   endfunction

   logic [N-1:0] count;
   logic [N-1:0] div_act;
   logic [N-1:0] div_nxt;

   logic [N-1:0] count_n;
   logic [N-1:0] div_act_n;
   logic [N-1:0] div_nxt_n;
   logic         div_pend_n;
   logic         clk_out_n;
   logic         tick_n;
   logic         run;
   logic         wrap;
   logic         apply;

`ifdef PRESCALER_ONESHOT_EN
   logic         running_n;
   assign run = ena && running;
`else
   assign run = ena;
`endif

   // Next-state logic. A period boundary is either a counting wrap or a
   // restart; that is the only moment a pending divisor may become active.
   // The output registers are evaluated against the post-edge count and
   // period so they line up with the cycle in which count is visible.
   always_comb begin
      count_n    = count;
      clk_out_n  = clk_out;
      tick_n     = 1'b0;
      wrap       = run && !restart && (count >= div_act - 1'b1);
      apply      = div_pend && (restart || wrap);
      div_act_n  = apply ? div_nxt : div_act;

      // A load in the boundary cycle lands after the old value was applied,
      // so it stays pending for the following boundary.
      div_nxt_n  = div_load ? clamp_div(div_in) : div_nxt;
      div_pend_n = div_load ? 1'b1 : (apply ? 1'b0 : div_pend);

      if (restart) begin
         count_n   = '0;
         clk_out_n = 1'b0;
      end else if (run) begin
         count_n   = wrap ? '0 : count + 1'b1;
         tick_n    = wrap;
         // Odd periods give the extra cycle to the low phase.
         clk_out_n = mode ? wrap : (count_n >= div_act_n - (div_act_n >> 1));
      end

`ifdef PRESCALER_ONESHOT_EN
      running_n = running;
      if (restart)
         running_n = 1'b1;
      else if (wrap && oneshot)
         running_n = 1'b0;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         count    <= '0;
         div_act  <= DIV_RST;
         div_nxt  <= DIV_RST;
         div_pend <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
`ifdef PRESCALER_ONESHOT_EN
         running  <= 1'b1;
`endif
      end else begin
         count    <= count_n;
         div_act  <= div_act_n;
         div_nxt  <= div_nxt_n;
         div_pend <= div_pend_n;
         clk_out  <= clk_out_n;
         tick     <= tick_n;
`ifdef PRESCALER_ONESHOT_EN
         running  <= running_n;
`endif
      end
   end

endmodule

// File: tb/tb_prescaler_prog.sv
// ---------------------------------------------------------------------------
// tb_prescaler_prog
//
// Scoreboard bench for prescaler_prog (N=8, DIV_DEFAULT=10). The driver
// applies directed and random inputs at the falling edge, advances a
// reference model that tracks the position inside the current period as a
// plain integer, and queues the outputs expected after the next rising
// edge. A separate monitor pops one expectation per cycle just after the
// rising edge and compares.
// ---------------------------------------------------------------------------
module tb_prescaler_prog;

   logic       clk_in;
   logic       rst;
   logic       ena;
   logic       restart;
   logic       mode;
   logic [7:0] div_in;
   logic       div_load;
   logic       div_pend;
   logic       clk_out;
   logic       tick;
   logic       oneshot;
   logic       running;

   typedef struct packed {
      logic pend;
      logic clk;
      logic tick;
      logic run;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference model: position within the period, period length, queued
   // divisor, and the registered outputs.
   int   mPos = 0;
   int   mPer = 10;
   int   mNxt = 10;
   bit   mPend = 0;
   bit   mTick = 0;
   bit   mClk = 0;
   bit   mRun = 1;

   prescaler_prog #(.N(8), .DIV_DEFAULT(10)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .ena      (ena),
      .restart  (restart),
      .mode     (mode),
      .div_in   (div_in),
      .div_load (div_load),
      .div_pend (div_pend),
      .clk_out  (clk_out),
`ifdef PRESCALER_ONESHOT_EN
      .tick     (tick),
      .oneshot  (oneshot),
      .running  (running)
`else
      .tick     (tick)
`endif
   );

`ifndef PRESCALER_ONESHOT_EN
   assign running = 1'b1;
`endif

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Advance the model across one rising edge with the given inputs.
   task automatic modelStep(input bit rs, input bit en, input bit rsp,
                            input bit md, input int di, input bit ld,
                            input bit os);
      bit counting;
      bit boundary;
      if (rs) begin
         mPos = 0; mPer = 10; mPend = 0; mTick = 0; mClk = 0; mRun = 1;
         return;
      end
      counting = en && mRun && !rsp;
      boundary = rsp || (counting && (mPos + 1 == mPer));
      if (rsp) begin
         mPos = 0; mTick = 0; mClk = 0; mRun = 1;
      end else if (counting) begin
         mPos  = (mPos + 1) % mPer;
         mTick = (mPos == 0);
         if (mTick && os) mRun = 0;
      end else begin
         mTick = 0;
      end
      if (boundary && mPend) begin
         mPer  = mNxt;
         mPend = 0;
      end
      if (ld) begin
         mNxt  = (di < 2) ? 2 : di;
         mPend = 1;
      end
      if (counting)
         mClk = md ? mTick : (mPos >= mPer - mPer / 2);
   endtask

   task automatic applyStimulus(input bit rs, input bit en, input bit rsp,
                                input bit md, input int di, input bit ld,
                                input bit os);
      exp_t e;
      @(negedge clk_in);
      rst      = rs;
      ena      = en;
      restart  = rsp;
      mode     = md;
      div_in   = 8'(di);
      div_load = ld;
      oneshot  = os;
      modelStep(rs, en, rsp, md, di, ld, os);
      e.pend = mPend;
      e.clk  = mClk;
      e.tick = mTick;
      e.run  = mRun;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      bit bad;
      checks++;
      bad = (div_pend !== e.pend) || (clk_out !== e.clk) || (tick !== e.tick);
`ifdef PRESCALER_ONESHOT_EN
      bad = bad || (running !== e.run);
`endif
      if (bad) begin
         errors++;
         $display("[TB] FAIL outputs cycle %0d: got pend=%b clk=%b tick=%b run=%b, want pend=%b clk=%b tick=%b run=%b",
                  cycle, div_pend, clk_out, tick, running, e.pend, e.clk, e.tick, e.run);
      end
   endtask

   // Monitor: one expectation per rising edge, sampled 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         cycle++;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit rs, en, rsp, md, ld, os;
      int di;
      md = 0; os = 0;

      // Reset, then free run at P=10 in square-wave mode.
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0);
      repeat (35) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      // Load 7 mid-period; the current period completes first.
      applyStimulus(0, 1, 0, 0, 7, 1, 0);
      repeat (30) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      // Loads of 0 and 1 both clamp to period 2.
      applyStimulus(0, 1, 0, 0, 0, 1, 0);
      repeat (10) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 1, 1, 0);
      repeat (10) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      // Back to P=10, then freeze for 3 cycles mid-period.
      applyStimulus(0, 1, 0, 0, 10, 1, 0);
      repeat (16) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (15) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      // Pulse mode at P=4, then restart with a pending divisor of 5.
      applyStimulus(0, 1, 0, 1, 4, 1, 0);
      repeat (14) applyStimulus(0, 1, 0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 5, 1, 0);
      applyStimulus(0, 1, 1, 1, 0, 0, 0);
      repeat (12) applyStimulus(0, 1, 0, 1, 0, 0, 0);
      // Restart with a simultaneous load keeps the new value pending.
      applyStimulus(0, 1, 1, 0, 3, 1, 0);
      repeat (12) applyStimulus(0, 1, 0, 0, 0, 0, 0);
`ifdef PRESCALER_ONESHOT_EN
      applyStimulus(0, 1, 0, 0, 6, 1, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 1);
      repeat (20) applyStimulus(0, 1, 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 1, 0, 0, 0, 1);
      repeat (10) applyStimulus(0, 1, 0, 0, 0, 0, 1);
`endif

      // Randomized traffic with short periods dominating.
      for (int i = 0; i < 2000; i++) begin
         rs  = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 7) != 0);
         rsp = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) md = ~md;
         ld  = ($urandom_range(0, 19) == 0);
         di  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 12));
`ifdef PRESCALER_ONESHOT_EN
         if ($urandom_range(0, 49) == 0) os = ~os;
`endif
         applyStimulus(rs, en, rsp, md, di, ld, os);
      end

      repeat (3) @(negedge clk_in);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prescaler_prog.md
Name: prescaler_prog

Overview:
Programmable-period clock prescaler, the parametrised successor to the fixed power-of-two divider. It divides clk_in by any runtime divisor P (2..2^N-1) and provides two outputs: clk_out, selectable between square wave and single-cycle pulse, and a separate one-cycle tick strobe. Divisor changes are applied glitch-free at period boundaries. It drives LED blinkers, shift-register steppers and baud or timing strobes in the board designs.

Parameters:
N, 24, counter and divisor width in bits
DIV_DEFAULT, 12000000, active divisor after reset (1 Hz at 12 MHz); values below 2 are clamped to 2

Ports:
clk_in  input  1  system clock
rst  input  1  synchronous reset, active-high
ena  input  1  count enable; low freezes the counter
restart  input  1  synchronous phase restart
mode  input  1  0 = square-wave clk_out, 1 = pulse clk_out
div_in  input  N  new divisor value
div_load  input  1  one-cycle strobe that captures div_in
div_pend  output  1  captured divisor is waiting to be applied
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle strobe per period, registered

Behaviour:
- Internal state:
  - count[N-1:0].
  - div_act[N-1:0], the active period P.
  - div_nxt[N-1:0], the pending divisor.
  - div_pend flag.
- Clamp rule: any divisor of 0 or 1, from div_in or DIV_DEFAULT, is stored as 2.
- Reset (rst=1, highest priority):
  - count=0, div_act=clamp(DIV_DEFAULT), div_pend=0.
  - clk_out=0, tick=0.
- Priority after reset: restart > ena.
- Counting when ena=1:
  - count increments each clk_in edge.
  - Wrap occurs when count==P-1; the next count is 0.
- Pending divisor at wrap: if div_pend=1, then div_act<=div_nxt and div_pend<=0 in the same edge.
- tick timing:
  - tick<=1 on the edge where the wrap occurs, so tick is high during the cycle with count==0.
  - tick is 0 in every other cycle.
- clk_out, registered, evaluated on the post-edge count and P:
  - mode=0: clk_out = (count >= P-(P>>1)). Low for P-(P>>1) cycles, high for P>>1 cycles. Odd P gives the extra cycle to the low phase.
  - mode=1: clk_out equals tick.
  - A mode change takes effect on the next edge.
- ena=0:
  - count, div_act and clk_out hold.
  - tick=0.
  - A pending divisor stays pending.
- div_load=1:
  - div_nxt<=clamp(div_in), div_pend<=1.
  - A later load before the wrap overwrites div_nxt.
  - A load in the wrap cycle applies the old div_nxt. The new value becomes pending (div_pend stays 1) and takes effect at the following wrap.
  - Loads are accepted regardless of ena.
- restart=1:
  - count<=0, tick<=0, clk_out<=0 (mode 0 and mode 1).
  - If div_pend=1, the pending divisor is applied at once and div_pend clears; a simultaneous div_load behaves as a load in a wrap cycle.
  - ena is ignored in this cycle.
- Output latency: one cycle from the counting edge. No combinational path from any input to any output.

Optional Feature:
PRESCALER_ONESHOT_EN
- With the macro defined:
  - Adds input oneshot (1 bit) and output running (1 bit).
  - running resets to 1 and is set to 1 by restart.
  - While oneshot=1, the wrap edge that asserts tick also clears running.
  - While running=0 the counter behaves exactly as ena=0 (holds at 0, clk_out holds, tick=0) until restart.
- Without the macro: neither port exists, and the counter is always free-running under ena.

Test Plan:
1. N=8, DIV_DEFAULT=10, release rst, ena=1, mode=0 -> clk_out low 5 / high 5 repeating; tick high in cycles 10, 20, 30 after reset release; div_pend=0.
2. div_load with div_in=7 at count=3 -> div_pend=1 until the wrap. The current 10-cycle period completes, then periods are 7 long: clk_out low 4 / high 3, tick spacing 7.
3. div_in=0, then div_in=1, each loaded and applied -> period 2: clk_out toggles every cycle, tick every 2 cycles.
4. ena=0 for 3 cycles at count=6 (P=10) -> count holds at 6, tick stays 0, the next tick arrives 13 cycles after the previous one, and no ticks are skipped.
5. mode=1, P=4 -> clk_out is identical to tick (one high cycle every 4). Then restart at count=2 with a pending div of 5 -> count=0 the next cycle, div_pend=0, tick=0, next tick 5 cycles later.
6. PRESCALER_ONESHOT_EN, oneshot=1, P=6 -> exactly one tick, 6 cycles after release, then running=0 and no further ticks; restart -> running=1, next tick 6 cycles later.
